// File: rtl/apb_pkg.sv
// +----------------------------------------------------------------------------+
// | apb_pkg: shared APB state encodings, GPIO register map and width defaults   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'b00,
    APB_SETUP  = 2'b01,
    APB_ACCESS = 2'b11
  } apb_state_t;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;

  localparam logic [APB_ADDR_WIDTH-1:0] GPIO_DATA_ADDR = 32'h0000_0000;
  localparam logic [APB_ADDR_WIDTH-1:0] GPIO_CTRL_ADDR = 32'h0000_0001;

  // A disabled watchdog (limit 0) still needs a 1-bit counter to be legal.
  function automatic int apb_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_wait_timer.sv
// +----------------------------------------------------------------------------+
// | apb_wait_timer: wait-state counter for the APB watchdog, expires at LIMIT  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module apb_wait_timer #(
  parameter int LIMIT     = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  generate
    if (LIMIT > 0) begin : g_timer
      localparam logic [CNT_WIDTH-1:0] c_limit = CNT_WIDTH'(LIMIT);
      logic [CNT_WIDTH-1:0] r_count;

      // Holds at the limit; the bridge aborts on that same cycle anyway.
      always_ff @(posedge clk) begin
        if (rst || i_clear) begin
          r_count <= '0;
        end else if (i_enable && (r_count != c_limit)) begin
          r_count <= r_count + CNT_WIDTH'(1);
        end
      end

      assign o_expired = (r_count == c_limit);
    end else begin : g_no_timer
      logic w_unused_inputs;
      assign w_unused_inputs = ^{clk, rst, i_clear, i_enable};
      assign o_expired       = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/apb_master_bridge.sv
// +----------------------------------------------------------------------------+
// | apb_master_bridge: valid/ready command to APB initiator with watchdog      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = apb_cnt_width(TIMEOUT_CYCLES)
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PWRITE,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  output logic [1:0]              State
);

  apb_state_t                r_state, w_next_state;
  logic [ADDR_WIDTH-1:0]     r_paddr;
  logic                      r_pwrite;
  logic [DATA_WIDTH-1:0]     r_pwdata;
  logic [DATA_WIDTH/8-1:0]   r_pstrb;
  logic                      r_rsp_valid, r_rsp_err, r_rsp_timeout;
  logic [DATA_WIDTH-1:0]     r_rsp_rdata;
  logic                      w_accept, w_complete, w_abort, w_expired;
  logic                      w_timer_clear, w_timer_enable;

  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      r_state <= APB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_accept       = cmd_valid && (r_state == APB_IDLE) && !r_rsp_valid;
    w_complete     = (r_state == APB_ACCESS) && PREADY;
    w_abort        = (r_state == APB_ACCESS) && !PREADY && w_expired;
    w_timer_clear  = (r_state == APB_SETUP);
    w_timer_enable = (r_state == APB_ACCESS) && !PREADY;
    case (r_state)
      APB_IDLE:   if (w_accept) w_next_state = APB_SETUP;
      APB_SETUP:  w_next_state = APB_ACCESS;
      APB_ACCESS: if (w_complete || w_abort) w_next_state = APB_IDLE;
      default:    w_next_state = APB_IDLE;
    endcase
  end

  apb_wait_timer #(
    .LIMIT     (TIMEOUT_CYCLES),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_wait_timer (
    .clk       (PCLK),
    .rst       (PRESETn),
    .i_clear   (w_timer_clear),
    .i_enable  (w_timer_enable),
    .o_expired (w_expired)
  );

  // Bus fields load only on accept, so they stay stable through SETUP/ACCESS.
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      r_paddr       <= '0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= '0;
    end else begin
      if (w_accept) begin
        r_paddr  <= cmd_addr;
        r_pwrite <= cmd_write;
        r_pwdata <= cmd_wdata;
        r_pstrb  <= cmd_write ? cmd_strb : '0;
      end
      if (w_complete) begin
        r_rsp_valid   <= 1'b1;
        r_rsp_err     <= PSLVERR;
        r_rsp_timeout <= 1'b0;
        r_rsp_rdata   <= r_pwrite ? '0 : PRDATA;
      end else if (w_abort) begin
        r_rsp_valid   <= 1'b1;
        r_rsp_err     <= 1'b1;
        r_rsp_timeout <= 1'b1;
        r_rsp_rdata   <= '0;
      end else if (r_rsp_valid && rsp_ready) begin
        r_rsp_valid   <= 1'b0;
      end
    end
  end

  assign cmd_ready   = (r_state == APB_IDLE) && !r_rsp_valid;
  assign PSEL        = (r_state == APB_SETUP) || (r_state == APB_ACCESS);
  assign PENABLE     = (r_state == APB_ACCESS);
  assign PADDR       = r_paddr;
  assign PWRITE      = r_pwrite;
  assign PWDATA      = r_pwdata;
  assign PSTRB       = r_pstrb;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign rsp_rdata   = r_rsp_rdata;
  assign State       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
// +----------------------------------------------------------------------------+
// | tb_apb_master_bridge: directed self-checking bench, watchdog limit of 4     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
  logic [3:0]  PSTRB;
  logic [1:0]  State;

  int n_checks = 0;
  int n_pass   = 0;
  int n_wait   = 0;
  int acc_cnt  = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PADDR       (PADDR),
    .PWRITE      (PWRITE),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWDATA      (PWDATA),
    .PSTRB       (PSTRB),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .State       (State)
  );

  // Slave: PREADY low for the first n_wait ACCESS cycles, high afterwards.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) acc_cnt = acc_cnt + 1;
    else                 acc_cnt = 0;
    PREADY = (acc_cnt > n_wait);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Issue one command; returns edges from accept (inclusive) to rsp_valid,
  // count of bus-field changes during the transfer and the PSTRB seen.
  task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int edges, output int unstable,
                         output logic [3:0] strb_seen);
    logic [31:0] addr0, data0;
    logic        wr0;
    edges = 0; unstable = 0; strb_seen = 4'hx;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    check("accept_ready", {63'd0, cmd_ready}, 64'd1);
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    addr0 = PADDR; data0 = PWDATA; wr0 = PWRITE; strb_seen = PSTRB;
    for (int k = 1; k <= 40; k++) begin
      if (rsp_valid) begin
        edges = k;
        break;
      end
      if (PADDR !== addr0 || PWDATA !== data0 || PWRITE !== wr0 || PSTRB !== strb_seen || !PSEL)
        unstable++;
      @(posedge PCLK);
      @(negedge PCLK);
    end
    if (edges == 0) check("rsp_wait_bound", 64'd0, 64'd1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int          edges, unstable, bad;
    logic [3:0]  strb_seen;

    PRESETn = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_state",  {62'd0, State}, 64'd0);
    check("rst_psel",   {62'd0, PSEL, PENABLE}, 64'd0);
    check("rst_rsp",    {61'd0, rsp_valid, rsp_err, rsp_timeout}, 64'd0);
    check("rst_paddr",  {32'd0, PADDR}, 64'd0);
    check("rst_cmdrdy", {63'd0, cmd_ready}, 64'd1);
    PRESETn = 1'b0;
    @(negedge PCLK);

    // Zero-wait write, cycle by cycle.
    n_wait = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h1; cmd_wdata = 32'hFF; cmd_strb = 4'b0001;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    check("wr_setup_state", {62'd0, State}, 64'h1);
    check("wr_setup_sel",   {62'd0, PSEL, PENABLE}, 64'b10);
    check("wr_setup_bus",   {PADDR, 27'd0, PWRITE, PSTRB}, {32'h1, 27'd0, 1'b1, 4'b0001});
    @(posedge PCLK);
    @(negedge PCLK);
    check("wr_access_sel",  {62'd0, PSEL, PENABLE}, 64'b11);
    check("wr_access_data", {32'd0, PWDATA}, 64'hFF);
    @(posedge PCLK);
    @(negedge PCLK);
    check("wr_rsp",     {29'd0, rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {29'd0, 3'b100, 32'h0});
    check("wr_idle",    {61'd0, PSEL, State}, 64'd0);
    check("wr_cmd_blk", {63'd0, cmd_ready}, 64'd0);
    consume();
    check("wr_consumed", {62'd0, rsp_valid, cmd_ready}, 64'b01);

    // Read with 3 wait states; read strobes must be forced to zero.
    n_wait = 3; PRDATA = 32'hA5;
    run_cmd(1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, edges, unstable, strb_seen);
    check("rd3_edges",  edges, 64'd6);
    check("rd3_stable", unstable, 64'd0);
    check("rd3_pstrb",  {60'd0, strb_seen}, 64'd0);
    check("rd3_rsp",    {29'd0, rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {29'd0, 3'b100, 32'hA5});
    consume();

    // Slave error on a write.
    n_wait = 0; PSLVERR = 1'b1;
    run_cmd(1'b1, 32'h0000_0000, 32'h1234_5678, 4'b0011, edges, unstable, strb_seen);
    check("err_pstrb", {60'd0, strb_seen}, 64'h3);
    check("err_rsp",   {61'd0, rsp_valid, rsp_err, rsp_timeout}, 64'b110);
    consume();
    PSLVERR = 1'b0;

    // Watchdog abort: 4 counted wait cycles, abort on the 5th ACCESS cycle.
    n_wait = 1000; PRDATA = 32'h5A5A_5A5A;
    run_cmd(1'b0, 32'h0000_0040, 32'h0, 4'h0, edges, unstable, strb_seen);
    check("to_edges", edges, 64'd7);
    check("to_rsp",   {29'd0, rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {29'd0, 3'b111, 32'h0});
    check("to_psel",  {61'd0, PSEL, State}, 64'd0);
    consume();

    // PREADY rises exactly when the wait count hits the limit: normal completion.
    n_wait = 4; PRDATA = 32'hC0DE;
    run_cmd(1'b0, 32'h0000_0044, 32'h0, 4'h0, edges, unstable, strb_seen);
    check("lim_edges", edges, 64'd7);
    check("lim_rsp",   {29'd0, rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {29'd0, 3'b100, 32'hC0DE});
    consume();

    // Follow-up read, response left pending for the backpressure test.
    n_wait = 1; PRDATA = 32'h1234;
    run_cmd(1'b0, 32'h0000_0008, 32'h0, 4'h0, edges, unstable, strb_seen);
    check("fu_edges", edges, 64'd4);
    check("fu_rsp",   {29'd0, rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {29'd0, 3'b100, 32'h1234});

    n_wait = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h1; cmd_wdata = 32'h77; cmd_strb = 4'hF;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge PCLK);
      @(negedge PCLK);
      if (cmd_ready !== 1'b0 || PSEL !== 1'b0 || rsp_valid !== 1'b1 ||
          rsp_rdata !== 32'h1234 || rsp_err !== 1'b0) bad++;
    end
    check("bp_hold", bad, 64'd0);
    rsp_ready = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    rsp_ready = 1'b0;
    check("bp_handshake", {61'd0, rsp_valid, cmd_ready, PSEL}, 64'b010);
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    check("bp_next_setup", {61'd0, PSEL, PENABLE, PWRITE}, 64'b101);
    bad = 1;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) begin bad = 0; break; end
      @(posedge PCLK);
      @(negedge PCLK);
    end
    check("bp_next_done", bad, 64'd0);
    consume();

    // Reset during a wait state.
    n_wait = 1000;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hABC; cmd_strb = 4'h0;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(posedge PCLK);
    @(posedge PCLK);
    @(negedge PCLK);
    check("mid_access", {62'd0, PSEL, PENABLE}, 64'b11);
    PRESETn = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    check("mr_bus",   {61'd0, PSEL, PENABLE, rsp_valid}, 64'd0);
    check("mr_state", {30'd0, State, PADDR}, 64'd0);
    PRESETn = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge PCLK);
      @(negedge PCLK);
      if (rsp_valid !== 1'b0 || PSEL !== 1'b0) bad++;
    end
    check("mr_no_rsp", bad, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
